sample_capture_buffer: RTL and testbench
========================================

Name: sample_capture_buffer

Overview:
- Write-side counterpart of the 256 x 8 signed sample ROM playback path.
- Records a stream of signed 8-bit audio samples (microphone/ADC front end) into a 256-entry RAM, starting when an amplitude threshold is first met.
- Exposes the captured record through a registered read port so downstream voice logic can replay or analyse it.

Parameters:
- DATA_W, 8, sample width; two's complement signed.
- ADDR_W, 8, RAM address width; depth = 2**ADDR_W = 256.
- THRESH, 20, trigger level; capture starts on the first sample with |s| >= THRESH (unsigned compare).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; arms capture.
- abort  in  1  one-cycle pulse; cancels armed or active capture.
- s_valid  in  1  input sample valid.
- s_data  in  DATA_W  signed input sample.
- s_ready  out  1  sample accepted when s_valid && s_ready.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  signed read data.
- rd_valid  out  1  rd_data valid, one cycle after rd_en.
- busy  out  1  high in ARMED or CAPTURE.
- done  out  1  high in DONE.
- count  out  ADDR_W+1  samples written in the current or last capture, 0..256.
- peak  out  DATA_W  peak magnitude (optional feature).

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - count=0, rd_data=0, rd_valid=0, peak=0, busy=0, done=0.
  - Internal write pointer = 0.
  - RAM contents are not cleared.
- s_ready:
  - 1 in IDLE, ARMED and CAPTURE. In IDLE, samples are accepted and discarded.
  - 0 in DONE (upstream stalls until re-armed).
- Magnitude:
  - |s| is computed in DATA_W+1 bits; -128 maps to 128.
  - No saturation before the compare.
- IDLE:
  - start moves to ARMED.
  - On that transition: write pointer=0, count=0, peak=0.
- ARMED:
  - Accepted samples with |s| < THRESH are discarded.
  - The first accepted sample with |s| >= THRESH is written to address 0, count becomes 1, and the state moves to CAPTURE in the same cycle.
- CAPTURE:
  - Every accepted sample is written at the write pointer; pointer and count increment.
  - The write to address 255 sets count=256 and moves to DONE on the next edge.
  - Write address wraps 255 -> 0 internally but is never used past 255.
- DONE:
  - Holds count=256.
  - start returns to ARMED, clearing count, pointer and peak; done falls the cycle after start is sampled.
- abort:
  - In ARMED or CAPTURE, moves to IDLE next edge.
  - count keeps the number already written; no write occurs on the abort cycle even if s_valid=1.
  - Ignored in IDLE and DONE.
- Simultaneous events:
  - abort beats start.
  - start in ARMED or CAPTURE is ignored.
  - A trigger sample in the same cycle as start (IDLE) is not captured; arming takes effect the next cycle.
- Read port:
  - Synchronous, fixed latency 1: rd_en at edge N gives rd_data=mem[rd_addr] and rd_valid=1 after edge N+1.
  - rd_valid is 0 otherwise; rd_data holds its last value.
  - Reads are legal in any state.
  - Read and write to the same address in the same cycle return the old data (read-first).
  - Addresses >= count return stale contents; no error is flagged.
- busy and done are registered and decode the current state.

Optional Feature:
- Macro: SAMPLE_CAPTURE_PEAK_EN.
- Defined:
  - peak tracks the maximum |s| over all samples written in the current capture, including the trigger sample.
  - Updates one cycle after the write.
  - -128 reports 128 (8'h80, interpreted unsigned).
  - Cleared on the start transition; held through DONE and IDLE.
- Undefined: the peak port exists but is tied to 0; no magnitude-max logic is synthesised.

Test Plan:
1. Reset mid-CAPTURE (after 10 writes): assert rst_n=0 -> immediately busy=0, count=0, s_ready=1; after release, state IDLE; reading addr 0..9 returns the earlier written data.
2. start, then samples 5, -19, -20, 7, ... (THRESH=20) -> 5 and -19 discarded; -20 stored at addr 0; 7 at addr 1; count=2 after those writes; busy=1.
3. Trigger, then 255 further samples of a known ramp -> done=1 and count=256 the cycle after the 256th write; s_ready=0; extra s_valid is not written; addresses 0..255 read back in order with rd_valid one cycle after rd_en.
4. abort after 37 writes, with start asserted in the same cycle -> IDLE next edge; count=37; no write on the abort cycle; start is ignored.
5. Same-address read during a write: rd_en at addr 3 while sample 3 is written -> rd_data is the previous contents; the next read of addr 3 returns the new sample.
6. PEAK_EN build: capture 30, -128, 90 -> peak=128; after re-arm, peak=0. Undefined build: peak=0 throughout.

Source files
------------

// File: rtl/sample_capture_buffer_if.sv
// Sample-stream, control and read-port bundle for sample_capture_buffer.
interface sample_capture_buffer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic                     start;
  logic                     abort;
  logic                     s_valid;
  logic signed [DATA_W-1:0] s_data;
  logic                     s_ready;
  logic                     rd_en;
  logic [ADDR_W-1:0]        rd_addr;
  logic signed [DATA_W-1:0] rd_data;
  logic                     rd_valid;
  logic                     busy;
  logic                     done;
  logic [ADDR_W:0]          count;
  logic [DATA_W-1:0]        peak;

  modport master (
    output start, abort, s_valid, s_data, rd_en, rd_addr,
    input  s_ready, rd_data, rd_valid, busy, done, count, peak
  );

  modport slave (
    input  start, abort, s_valid, s_data, rd_en, rd_addr,
    output s_ready, rd_data, rd_valid, busy, done, count, peak
  );
endinterface

// File: rtl/sample_capture_buffer.sv
// Threshold-triggered capture of signed samples into a 2**ADDR_W RAM with a registered read port.
// Optional peak-magnitude tracking is enabled by defining SAMPLE_CAPTURE_PEAK_EN.
module sample_capture_buffer #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int THRESH = 20
) (
   input logic                   clk,
   input logic                   rst_n,
   sample_capture_buffer_if.slave bus
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [DATA_W:0] THRESH_M = (DATA_W+1)'(THRESH);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ARMED   = 2'd1;
   localparam logic [1:0] CAPTURE = 2'd2;
   localparam logic [1:0] DONE    = 2'd3;

   // Magnitude needs one extra bit so that the most negative code maps to +2**(DATA_W-1).
   function automatic logic [DATA_W:0] mag_f(input logic signed [DATA_W-1:0] s);
      logic [DATA_W:0] x;
      x = {s[DATA_W-1], s};
      return s[DATA_W-1] ? (~x + 1'b1) : x;
   endfunction

   logic [1:0]          state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic                busy_q, done_q;
   logic                rd_valid_q;
   logic signed [DATA_W-1:0] rd_data_q;
   logic signed [DATA_W-1:0] mem [DEPTH];

   logic                we;
   logic                clr_peak;
   logic                accept;
   logic [DATA_W:0]     mag;

   assign mag    = mag_f(bus.s_data);
   assign accept = bus.s_valid && (state_q != DONE);

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      count_d  = count_q;
      we       = 1'b0;
      clr_peak = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d  = ARMED;
               ptr_d    = '0;
               count_d  = '0;
               clr_peak = 1'b1;
            end
         end
         ARMED: begin
            if (bus.abort) begin
               state_d = IDLE;
            end else if (accept && (mag >= THRESH_M)) begin
               we      = 1'b1;
               ptr_d   = ptr_q + ADDR_W'(1);
               count_d = count_q + (ADDR_W+1)'(1);
               state_d = CAPTURE;
            end
         end
         default: begin
            // Aborting drops the sample offered in the same cycle.
            if (bus.abort) begin
               state_d = IDLE;
            end else if (accept) begin
               we      = 1'b1;
               ptr_d   = ptr_q + ADDR_W'(1);
               count_d = count_q + (ADDR_W+1)'(1);
               if (ptr_q == '1) state_d = DONE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         count_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         count_q <= count_d;
         busy_q  <= (state_d == ARMED) || (state_d == CAPTURE);
         done_q  <= (state_d == DONE);
      end
   end

   always_ff @(posedge clk) begin
      if (we) mem[ptr_q] <= bus.s_data;
   end

   // Nonblocking RAM update makes a same-address read return the old word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= bus.rd_en;
         if (bus.rd_en) rd_data_q <= mem[bus.rd_addr];
      end
   end

`ifdef SAMPLE_CAPTURE_PEAK_EN
   logic              pk_vld_q;
   logic [DATA_W-1:0] pk_mag_q, peak_q;

   // The max is folded in one cycle after the write; a re-arm discards any pending update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pk_vld_q <= 1'b0;
         pk_mag_q <= '0;
         peak_q   <= '0;
      end else if (clr_peak) begin
         pk_vld_q <= 1'b0;
         peak_q   <= '0;
      end else begin
         pk_vld_q <= we;
         pk_mag_q <= mag[DATA_W-1:0];
         if (pk_vld_q && (pk_mag_q > peak_q)) peak_q <= pk_mag_q;
      end
   end

   assign bus.peak = peak_q;
`else
   assign bus.peak = '0;
`endif

   assign bus.s_ready  = (state_q != DONE);
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.count    = count_q;
   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_sample_capture_buffer.sv
// Directed-sequence bench with randomized sample data for sample_capture_buffer.
module tb_sample_capture_buffer;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  logic [7:0] ref_mem [256];
  logic [7:0] cap [256];

  sample_capture_buffer_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  sample_capture_buffer #(.DATA_W(8), .ADDR_W(8), .THRESH(20)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    cyc();
    bus.s_valid = 1'b0;
  endtask

  task automatic rd(input int a, input string tag);
    bus.rd_en   = 1'b1;
    bus.rd_addr = 8'(a);
    cyc();
    bus.rd_en = 1'b0;
    chk({tag, "_vld"}, 32'(bus.rd_valid), 1);
    chk(tag, 32'({bus.rd_data}), 32'(ref_mem[a]));
  endtask

  function automatic int magf(input logic [7:0] v);
    int s;
    s = int'($signed(v));
    return (s < 0) ? -s : s;
  endfunction

  function automatic logic [7:0] rand_trig();
    int m;
    m = int'($urandom_range(128, 20));
    if (m == 128) return 8'h80;
    return ($urandom_range(1, 0) == 1) ? 8'(-m) : 8'(m);
  endfunction

  function automatic logic [7:0] rand_sub();
    return 8'(int'($urandom_range(38, 0)) - 19);
  endfunction

  function automatic int exp_peak(input int v);
`ifdef SAMPLE_CAPTURE_PEAK_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  initial begin
    int pk;
    int base;
    int step;
    logic [7:0] old3;

    n_cmp = 0;
    n_fail = 0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0;
    bus.rd_en = 1'b0; bus.rd_addr = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 0);
    chk("rst_rd_data", 32'({bus.rd_data}), 0);
    chk("rst_peak", 32'(bus.peak), 0);
    chk("rst_s_ready", 32'(bus.s_ready), 1);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // Arm, discard sub-threshold samples, trigger on -20.
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    chk("arm_busy", 32'(bus.busy), 1);
    send(8'd5);
    send(8'(-19));
    chk("sub_thr_count", 32'(bus.count), 0);
    send(8'(-20));
    ref_mem[0] = 8'(-20);
    chk("trig_count", 32'(bus.count), 1);
    send(8'd7);
    ref_mem[1] = 8'd7;
    chk("second_count", 32'(bus.count), 2);
    chk("cap_busy", 32'(bus.busy), 1);
    for (int i = 2; i < 10; i++) begin
      ref_mem[i] = 8'($urandom_range(255, 0));
      send(ref_mem[i]);
    end
    chk("ten_count", 32'(bus.count), 10);

    // Asynchronous reset in the middle of a capture; RAM keeps its contents.
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_count", 32'(bus.count), 0);
    chk("midrst_s_ready", 32'(bus.s_ready), 1);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("postrst_busy", 32'(bus.busy), 0);
    chk("postrst_done", 32'(bus.done), 0);
    for (int i = 0; i < 10; i++) rd(i, "rd_after_rst");

    // Full capture: trigger plus a 255-sample ramp, with a same-address read at addr 3.
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    for (int i = 0; i < 3; i++) send(rand_sub());
    chk("full_pre_count", 32'(bus.count), 0);
    base = int'($urandom_range(255, 0));
    step = int'($urandom_range(5, 1));
    cap[0] = rand_trig();
    for (int i = 1; i < 256; i++) cap[i] = 8'(base + step * i);
    pk = 0;
    for (int i = 0; i < 256; i++) if (magf(cap[i]) > pk) pk = magf(cap[i]);
    old3 = ref_mem[3];
    for (int i = 0; i < 256; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = cap[i];
      if (i == 3) begin
        bus.rd_en   = 1'b1;
        bus.rd_addr = 8'd3;
      end
      cyc();
      bus.s_valid = 1'b0;
      bus.rd_en   = 1'b0;
      if (i == 3) begin
        chk("same_addr_vld", 32'(bus.rd_valid), 1);
        chk("same_addr_old", 32'({bus.rd_data}), 32'(old3));
      end
      ref_mem[i] = cap[i];
      chk("full_count", 32'(bus.count), i + 1);
    end
    chk("full_done", 32'(bus.done), 1);
    chk("full_busy", 32'(bus.busy), 0);
    chk("full_s_ready", 32'(bus.s_ready), 0);
    bus.s_valid = 1'b1; bus.s_data = ~cap[0];
    cyc(); cyc();
    bus.s_valid = 1'b0;
    chk("done_hold_count", 32'(bus.count), 256);
    chk("done_hold", 32'(bus.done), 1);
    chk("full_peak", 32'(bus.peak), exp_peak(pk));
    for (int i = 0; i < 256; i++) rd(i, "full_rd");
    cyc();
    chk("rd_valid_idle", 32'(bus.rd_valid), 0);

    // Re-arm from DONE, capture 37 samples, then abort with start in the same cycle.
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    chk("rearm_done", 32'(bus.done), 0);
    chk("rearm_busy", 32'(bus.busy), 1);
    chk("rearm_count", 32'(bus.count), 0);
    chk("rearm_peak", 32'(bus.peak), 0);
    ref_mem[0] = rand_trig();
    send(ref_mem[0]);
    for (int i = 1; i < 37; i++) begin
      ref_mem[i] = 8'($urandom_range(255, 0));
      send(ref_mem[i]);
    end
    chk("pre_abort_count", 32'(bus.count), 37);
    bus.abort = 1'b1; bus.start = 1'b1; bus.s_valid = 1'b1; bus.s_data = ~ref_mem[37];
    cyc();
    bus.abort = 1'b0; bus.start = 1'b0; bus.s_valid = 1'b0;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_done", 32'(bus.done), 0);
    chk("abort_count", 32'(bus.count), 37);
    cyc();
    chk("abort_start_ignored", 32'(bus.busy), 0);
    send(8'd100);
    chk("idle_discard_count", 32'(bus.count), 37);
    rd(36, "abort_rd36");
    rd(37, "abort_rd37");

    // Trigger level sample coincident with start is not captured; then peak of 30,-128,90.
    bus.start = 1'b1; bus.s_valid = 1'b1; bus.s_data = 8'd100;
    cyc();
    bus.start = 1'b0; bus.s_valid = 1'b0;
    chk("start_trig_busy", 32'(bus.busy), 1);
    chk("start_trig_count", 32'(bus.count), 0);
    send(8'd30);
    send(8'h80);
    send(8'd90);
    ref_mem[0] = 8'd30; ref_mem[1] = 8'h80; ref_mem[2] = 8'd90;
    chk("pk_count", 32'(bus.count), 3);
    cyc(); cyc();
    chk("pk_value", 32'(bus.peak), exp_peak(128));
    rd(1, "pk_rd1");
    bus.abort = 1'b1; cyc(); bus.abort = 1'b0;
    cyc();
    chk("pk_hold_idle", 32'(bus.peak), exp_peak(128));
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    cyc();
    chk("pk_cleared", 32'(bus.peak), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
